// File: rtl/keccak_absorb_ctrl_if.sv
// Handshake and datapath-control bundle between the Keccak absorb sequencer,
// the double-buffered input stage, the permutation datapath and the squeeze stage.
interface keccak_absorb_ctrl_if #(
    parameter int RIW   = 5,
    parameter int CNT_W = 16
);
    logic             block_valid;
    logic             block_last;
    logic             block_ready;
    logic             absorb_en;
    logic             round_en;
    logic [RIW-1:0]   round_index;
    logic             state_clear;
    logic             hash_valid;
    logic             hash_ack;
    logic             busy;
    logic [CNT_W-1:0] block_count;

    // master: the sequencer itself
    modport master (
        input  block_valid, block_last, hash_ack,
        output block_ready, absorb_en, round_en, round_index,
               state_clear, hash_valid, busy, block_count
    );

    // slave: input buffer, permutation datapath and output stage
    modport slave (
        output block_valid, block_last, hash_ack,
        input  block_ready, absorb_en, round_en, round_index,
               state_clear, hash_valid, busy, block_count
    );
endinterface

// File: rtl/keccak_absorb_ctrl.sv
// Keccak-f[1600] absorb/permute sequencer with Moore (registered) outputs.
// Macro KECCAK_CTRL_BLOCK_COUNT_EN builds the saturating block counter; otherwise a 1-bit absorbed-any flag.
module keccak_absorb_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int RIW        = $clog2(NUM_ROUNDS),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    keccak_absorb_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_ROUND  = 3'd2,
        S_DONE   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    localparam logic [RIW-1:0] LAST_ROUND = RIW'(NUM_ROUNDS - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [RIW-1:0] r_round;
    logic [RIW-1:0] w_round_next;
    logic           w_any_absorbed;

    logic r_absorb_en;
    logic r_block_ready;
    logic r_round_en;
    logic r_state_clear;
    logic r_hash_valid;
    logic r_busy;

    always_comb begin
        w_state_next = r_state;
        w_round_next = '0;
        case (r_state)
            S_IDLE: begin
                // A close request with nothing absorbed means the padded block is still on its way.
                if (bus.block_valid)
                    w_state_next = S_ABSORB;
                else if (bus.block_last && w_any_absorbed)
                    w_state_next = S_DONE;
            end
            S_ABSORB: begin
                w_state_next = S_ROUND;
            end
            S_ROUND: begin
                if (r_round == LAST_ROUND)
                    w_state_next = bus.block_valid ? S_ABSORB : S_IDLE;
                else
                    w_round_next = r_round + 1'b1;
            end
            S_DONE: begin
                if (bus.hash_ack)
                    w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every one of them leaves a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_round       <= '0;
            r_absorb_en   <= 1'b0;
            r_block_ready <= 1'b0;
            r_round_en    <= 1'b0;
            r_state_clear <= 1'b0;
            r_hash_valid  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_round       <= w_round_next;
            r_absorb_en   <= (w_state_next == S_ABSORB);
            r_block_ready <= (w_state_next == S_ABSORB);
            r_round_en    <= (w_state_next == S_ROUND);
            r_state_clear <= (w_state_next == S_CLEAR);
            r_hash_valid  <= (w_state_next == S_DONE);
            r_busy        <= (w_state_next != S_IDLE);
        end
    end

`ifdef KECCAK_CTRL_BLOCK_COUNT_EN
    logic [CNT_W-1:0] r_block_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block_count <= '0;
        end else if (w_state_next == S_CLEAR) begin
            r_block_count <= '0;
        end else if ((w_state_next == S_ABSORB) && (r_block_count != {CNT_W{1'b1}})) begin
            r_block_count <= r_block_count + 1'b1;
        end
    end

    assign w_any_absorbed  = (r_block_count != '0);
    assign bus.block_count = r_block_count;
`else
    logic r_any_absorbed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_absorbed <= 1'b0;
        end else if (w_state_next == S_CLEAR) begin
            r_any_absorbed <= 1'b0;
        end else if (w_state_next == S_ABSORB) begin
            r_any_absorbed <= 1'b1;
        end
    end

    assign w_any_absorbed  = r_any_absorbed;
    assign bus.block_count = {CNT_W{1'b0}};
`endif

    assign bus.absorb_en   = r_absorb_en;
    assign bus.block_ready = r_block_ready;
    assign bus.round_en    = r_round_en;
    assign bus.round_index = r_round;
    assign bus.state_clear = r_state_clear;
    assign bus.hash_valid  = r_hash_valid;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Directed bench for keccak_absorb_ctrl: 24 rounds, 2-bit block counter so saturation is reachable.
module tb_keccak_absorb_ctrl;
    localparam int NR  = 24;
    localparam int RIW = 5;
    localparam int CW  = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    keccak_absorb_ctrl_if #(.RIW(RIW), .CNT_W(CW)) bus ();

    keccak_absorb_ctrl #(.NUM_ROUNDS(NR), .RIW(RIW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef KECCAK_CTRL_BLOCK_COUNT_EN
        return (n > 3) ? 2'd3 : CW'(n);
`else
        return 2'd0;
`endif
    endfunction

    // Invariants checked every cycle away from the clock edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks = checks + 1;
            if ((bus.absorb_en && bus.round_en) || (bus.round_index > RIW'(NR - 1)) ||
                (bus.block_ready !== bus.absorb_en) || (!bus.round_en && bus.round_index != '0)) begin
                errors = errors + 1;
                $display("FAIL invariant t=%0t absorb=%b round=%b ready=%b idx=%0d", $time,
                         bus.absorb_en, bus.round_en, bus.block_ready, bus.round_index);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.block_valid = 1'b0;
        bus.block_last  = 1'b0;
        bus.hash_ack    = 1'b0;
        repeat (3) tick();
        checks = checks + 1;
        if ({bus.absorb_en, bus.block_ready, bus.round_en, bus.state_clear, bus.hash_valid, bus.busy} !== 6'b0) begin
            errors = errors + 1;
            $display("FAIL reset_strobes got=%b want=000000",
                     {bus.absorb_en, bus.block_ready, bus.round_en, bus.state_clear, bus.hash_valid, bus.busy});
        end
        checks = checks + 1;
        if (bus.round_index !== '0 || bus.block_count !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_idx_cnt got idx=%0d cnt=%0d want 0 0", bus.round_index, bus.block_count);
        end
        reset = 1'b0;
        tick();
    endtask

    // Close a message from IDLE: block_last, wait for hash_valid, ack, clear.
    task automatic close_msg(input string tag, input int n_blocks);
        int waited;
        bus.block_last = 1'b1;
        tick();
        bus.block_last = 1'b0;
        waited = 0;
        while (bus.hash_valid !== 1'b1 && waited < 5) begin
            tick();
            waited++;
        end
        checks = checks + 1;
        if (bus.hash_valid !== 1'b1 || waited != 0) begin
            errors = errors + 1;
            $display("FAIL %s_hash_valid got=%b after %0d extra cycles want=1 after 0", tag, bus.hash_valid, waited);
        end
        checks = checks + 1;
        if (bus.block_count !== exp_cnt(n_blocks)) begin
            errors = errors + 1;
            $display("FAIL %s_count got=%0d want=%0d", tag, bus.block_count, exp_cnt(n_blocks));
        end
        bus.hash_ack = 1'b1;
        tick();
        bus.hash_ack = 1'b0;
        checks = checks + 1;
        if (bus.state_clear !== 1'b1 || bus.hash_valid !== 1'b0 || bus.block_count !== '0) begin
            errors = errors + 1;
            $display("FAIL %s_clear got clr=%b hv=%b cnt=%0d want 1 0 0", tag,
                     bus.state_clear, bus.hash_valid, bus.block_count);
        end
        tick();
        checks = checks + 1;
        if (bus.busy !== 1'b0 || bus.state_clear !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s_idle got busy=%b clr=%b want 0 0", tag, bus.busy, bus.state_clear);
        end
        $display("close_msg %s: blocks=%0d done", tag, n_blocks);
    endtask

    task automatic test_single_block();
        bus.block_valid = 1'b1;                 // cycle t
        tick();                                 // t+1
        bus.block_valid = 1'b0;
        checks = checks + 1;
        if (bus.absorb_en !== 1'b1 || bus.block_ready !== 1'b1 || bus.round_en !== 1'b0 ||
            bus.block_count !== exp_cnt(1)) begin
            errors = errors + 1;
            $display("FAIL single_absorb got ab=%b rdy=%b re=%b cnt=%0d want 1 1 0 %0d",
                     bus.absorb_en, bus.block_ready, bus.round_en, bus.block_count, exp_cnt(1));
        end
        for (int r = 0; r < NR; r++) begin      // t+2 .. t+25
            tick();
            checks = checks + 1;
            if (bus.round_en !== 1'b1 || bus.round_index !== RIW'(r) || bus.absorb_en !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL single_round%0d got re=%b idx=%0d ab=%b want 1 %0d 0",
                         r, bus.round_en, bus.round_index, bus.absorb_en, r);
            end
        end
        tick();                                 // t+26, IDLE
        checks = checks + 1;
        if (bus.busy !== 1'b0 || bus.round_en !== 1'b0 || bus.block_count !== exp_cnt(1)) begin
            errors = errors + 1;
            $display("FAIL single_idle got busy=%b re=%b cnt=%0d want 0 0 %0d",
                     bus.busy, bus.round_en, bus.block_count, exp_cnt(1));
        end
        bus.block_last = 1'b1;
        tick();                                 // t+27
        bus.block_last = 1'b0;
        for (int c = 27; c <= 30; c++) begin
            checks = checks + 1;
            if (bus.hash_valid !== 1'b1 || bus.busy !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL single_hv_t%0d got hv=%b busy=%b want 1 1", c, bus.hash_valid, bus.busy);
            end
            if (c == 30) bus.hash_ack = 1'b1;
            tick();
        end                                     // now t+31
        bus.hash_ack = 1'b0;
        checks = checks + 1;
        if (bus.hash_valid !== 1'b0 || bus.state_clear !== 1'b1 || bus.block_count !== '0) begin
            errors = errors + 1;
            $display("FAIL single_clear got hv=%b clr=%b cnt=%0d want 0 1 0",
                     bus.hash_valid, bus.state_clear, bus.block_count);
        end
        tick();                                 // t+32
        checks = checks + 1;
        if (bus.busy !== 1'b0 || bus.state_clear !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL single_end got busy=%b clr=%b want 0 0", bus.busy, bus.state_clear);
        end
        $display("test_single_block: complete");
    endtask

    task automatic test_back_to_back();
        bus.block_valid = 1'b1;                 // cycle t
        for (int k = 1; k <= 76; k++) begin
            tick();
            if (k == 74) bus.block_valid = 1'b0;
            if (k <= 75) begin
                checks = checks + 1;
                if (bus.absorb_en !== (k == 1 || k == 26 || k == 51) || bus.busy !== 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL b2b_t%0d got ab=%b busy=%b want %b 1",
                             k, bus.absorb_en, bus.busy, (k == 1 || k == 26 || k == 51));
                end
            end else begin
                checks = checks + 1;
                if (bus.busy !== 1'b0 || bus.block_count !== exp_cnt(3)) begin
                    errors = errors + 1;
                    $display("FAIL b2b_end got busy=%b cnt=%0d want 0 %0d", bus.busy, bus.block_count, exp_cnt(3));
                end
            end
        end
        $display("test_back_to_back: three blocks absorbed");
        close_msg("b2b", 3);
    endtask

    task automatic test_empty_guard();
        bus.block_last = 1'b1;
        bus.hash_ack   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks = checks + 1;
            if (bus.hash_valid !== 1'b0 || bus.busy !== 1'b0 || bus.state_clear !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL empty_guard_c%0d got hv=%b busy=%b clr=%b want 0 0 0",
                         k, bus.hash_valid, bus.busy, bus.state_clear);
            end
        end
        bus.block_last = 1'b0;
        bus.hash_ack   = 1'b0;
        tick();
        $display("test_empty_guard: stayed idle");
    endtask

    task automatic test_simultaneous();
        bus.block_valid = 1'b1;
        bus.block_last  = 1'b1;                 // cycle t, held through the rounds
        tick();
        bus.block_valid = 1'b0;
        checks = checks + 1;
        if (bus.absorb_en !== 1'b1 || bus.hash_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL simul_absorb got ab=%b hv=%b want 1 0", bus.absorb_en, bus.hash_valid);
        end
        for (int k = 2; k <= 25; k++) begin
            tick();
            checks = checks + 1;
            if (bus.hash_valid !== 1'b0 || bus.round_en !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL simul_t%0d got hv=%b re=%b want 0 1", k, bus.hash_valid, bus.round_en);
            end
        end
        tick();                                 // t+26 IDLE, block_last sampled here
        checks = checks + 1;
        if (bus.busy !== 1'b0 || bus.hash_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL simul_idle got busy=%b hv=%b want 0 0", bus.busy, bus.hash_valid);
        end
        tick();                                 // t+27
        bus.block_last = 1'b0;
        checks = checks + 1;
        if (bus.hash_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL simul_done got hv=%b want 1", bus.hash_valid);
        end
        bus.hash_ack = 1'b1;
        tick();
        bus.hash_ack = 1'b0;
        tick();
        $display("test_simultaneous: absorb first, then done");
    endtask

    task automatic test_reset_abort();
        bus.block_valid = 1'b1;
        tick();
        bus.block_valid = 1'b0;
        repeat (11) tick();                     // round index 10
        checks = checks + 1;
        if (bus.round_index !== RIW'(10) || bus.block_count !== exp_cnt(1)) begin
            errors = errors + 1;
            $display("FAIL abort_pre got idx=%0d cnt=%0d want 10 %0d", bus.round_index, bus.block_count, exp_cnt(1));
        end
        #1 reset = 1'b1;
        #1;
        checks = checks + 1;
        if (bus.round_en !== 1'b0 || bus.round_index !== '0 || bus.busy !== 1'b0 || bus.block_count !== '0) begin
            errors = errors + 1;
            $display("FAIL abort_async got re=%b idx=%0d busy=%b cnt=%0d want 0 0 0 0",
                     bus.round_en, bus.round_index, bus.busy, bus.block_count);
        end
        tick();
        #2 reset = 1'b0;
        tick();
        bus.block_valid = 1'b1;
        tick();
        bus.block_valid = 1'b0;
        checks = checks + 1;
        if (bus.absorb_en !== 1'b1 || bus.block_count !== exp_cnt(1)) begin
            errors = errors + 1;
            $display("FAIL abort_fresh got ab=%b cnt=%0d want 1 %0d", bus.absorb_en, bus.block_count, exp_cnt(1));
        end
        repeat (NR + 1) tick();
        $display("test_reset_abort: aborted and restarted");
        close_msg("abort", 1);
    endtask

    task automatic test_saturation();
        for (int b = 0; b < 5; b++) begin
            bus.block_valid = 1'b1;
            tick();
            bus.block_valid = 1'b0;
            repeat (NR + 1) tick();
        end
        checks = checks + 1;
        if (bus.block_count !== exp_cnt(5) || bus.busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL sat_count got cnt=%0d busy=%b want %0d 0", bus.block_count, bus.busy, exp_cnt(5));
        end
        $display("test_saturation: five blocks, count=%0d", bus.block_count);
        close_msg("sat", 5);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_empty_guard();
        test_single_block();
        test_back_to_back();
        test_simultaneous();
        test_reset_abort();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keccak_absorb_ctrl.md
# keccak_absorb_ctrl

Sequencer for the Keccak-f[1600] core. It pulls rate-sized blocks from the double-buffered input stage, issues one absorb (XOR-into-state) strobe per block, and steps the permutation through its rounds. When the input stage reports that the message is complete, it presents the finished state to the squeeze/output stage. It sits between the input buffer's output handshake and the permutation datapath.

## Interface
Parameters:
- NUM_ROUNDS, 24: permutation rounds per block; must be ≥2.
- RIW, $clog2(NUM_ROUNDS): width of round_index.
- CNT_W, 16: width of block_count.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- block_valid  in  1  input buffer holds a full block (buffer_output_valid).
- block_last  in  1  input stage fully drained and message closed (last_block_output).
- block_ready  out  1  one-cycle consume strobe to the input buffer (output_ready).
- absorb_en  out  1  XOR the current buffer block into the state this cycle.
- round_en  out  1  apply one permutation round this cycle.
- round_index  out  RIW  round-constant index; 0 whenever round_en=0.
- state_clear  out  1  one-cycle strobe: zero the 1600-bit state.
- hash_valid  out  1  state holds the final result.
- hash_ack  in  1  consumer has taken the result.
- busy  out  1  high in every state except IDLE.
- block_count  out  CNT_W  blocks absorbed in the current message; saturating.

## Operation
- All outputs are registered (Moore). Reset value of every output is 0; the FSM resets to IDLE and the count resets to 0.
- FSM states: IDLE, ABSORB, ROUND, DONE, CLEAR.
- IDLE:
  - block_valid=1 → ABSORB. block_valid has priority over block_last.
  - Else block_last=1 and block_count≠0 → DONE.
  - Else block_last=1 with block_count=0 is ignored; the padded block is still in flight.
- ABSORB: exactly one cycle. absorb_en=1 and block_ready=1. block_count increments, saturating at 2^CNT_W−1. Next state: ROUND with round_index=0.
- ROUND: round_en=1. round_index increments each cycle.
  - At index NUM_ROUNDS−1, go to ABSORB if block_valid=1 (back-to-back), else go to IDLE.
  - block_last is not sampled in ROUND.
- DONE: hash_valid=1, held until hash_ack=1 is sampled, then → CLEAR.
- CLEAR: exactly one cycle. state_clear=1 and block_count is cleared to 0. Next state: IDLE.
- Ignored inputs:
  - hash_ack outside DONE.
  - block_valid outside IDLE and the final ROUND cycle. The buffer holds it, so nothing is lost.
- Reset asserted mid-message aborts immediately. All strobes drop asynchronously and no partial hash_valid is produced.

## Timing
- block_valid is sampled high in IDLE at cycle t:
  - ABSORB at t+1.
  - Rounds 0..NUM_ROUNDS−1 at t+2..t+NUM_ROUNDS+1.
  - The next ABSORB is at the earliest t+NUM_ROUNDS+2.
- Sustained throughput is one block per NUM_ROUNDS+1 cycles.
- Final block: IDLE with block_last=1 at cycle u → hash_valid from u+1.
- hash_ack sampled high at cycle v → hash_valid drops at v+1 with state_clear=1 in the same cycle → IDLE at v+2.
- absorb_en and round_en are never high in the same cycle.
- block_ready is high only in ABSORB.
- round_index never exceeds NUM_ROUNDS−1.

## Configuration
- KECCAK_CTRL_BLOCK_COUNT_EN defined:
  - The CNT_W saturating counter is built and drives block_count.
  - The IDLE→DONE guard uses block_count≠0.
- Undefined:
  - block_count is tied to 0.
  - A 1-bit "absorbed-any" flag replaces the guard. It is set in ABSORB and cleared in CLEAR or by reset.
  - FSM behaviour and timing are otherwise identical.

## Test plan
- One block, NUM_ROUNDS=24:
  - Stimulus: block_valid at t; block_last at t+26; hash_ack at t+30.
  - Required: absorb_en and block_ready at t+1; round_en t+2..t+25 with round_index 0..23; hash_valid t+27..t+30; state_clear at t+31; block_count=1 until CLEAR.
- Back-to-back, three blocks: block_valid held high → ABSORB at t+1, t+26 and t+51; no IDLE cycle between them; block_count reaches 3.
- Empty-guard: block_last=1 in IDLE after reset with no block absorbed → FSM stays IDLE; hash_valid and busy stay 0.
- Simultaneous block_valid and block_last in IDLE → ABSORB taken; DONE follows only after the rounds complete and block_last is sampled again in IDLE.
- Reset asserted at round_index=10 → round_en, round_index, busy and block_count all 0 without waiting for a clock edge; a fresh block then absorbs normally.
- With the macro defined and CNT_W=2, five blocks → block_count saturates at 3; hash_valid is still produced after block_last.
